// File: rtl/seg7_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg7_pkg : BCD digit width and active-low seven-segment codes         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package seg7_pkg;
    localparam int         BCD_W     = 4;
    localparam logic       DP_OFF    = 1'b1;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg7_decode : combinational BCD to active-low {g..a} segments         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/counter_7seg_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | counter_7seg_mux : N-digit BCD up/down counter, multiplexed display   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module counter_7seg_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        up_dn,
    input  logic                        clear,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic [7:0]                  cathode,
    output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
    output logic                        wrap
);
    localparam int CW = BCD_W * NUM_DIGITS;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [TW-1:0]         presc_q, presc_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [SW-1:0]         scan_q, scan_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [7:0]            cathode_q, cathode_d;

    logic                  tick;
    logic                  carry;
    logic [BCD_W-1:0]      digit;
    logic [BCD_W-1:0]      sel_digit;
    logic                  zero_above;
    logic                  blank_sel;
    logic [6:0]            seg;

    // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
    always_comb begin
        tick    = en && (presc_q == TICK_LAST);
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        digit   = '0;
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digit = count_q[i*BCD_W +: BCD_W];
                    if (carry) begin
                        if (up_dn) begin
                            if (digit == 4'd9) begin
                                count_d[i*BCD_W +: BCD_W] = 4'd0;
                            end else begin
                                count_d[i*BCD_W +: BCD_W] = digit + 1'b1;
                                carry = 1'b0;
                            end
                        end else begin
                            if (digit == 4'd0) begin
                                count_d[i*BCD_W +: BCD_W] = 4'd9;
                            end else begin
                                count_d[i*BCD_W +: BCD_W] = digit - 1'b1;
                                carry = 1'b0;
                            end
                        end
                    end
                end
                wrap_d = carry;
            end
        end
    end

    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Walk from the top digit down so zero_above covers this digit and all above it.
    always_comb begin
        sel_digit  = '0;
        blank_sel  = 1'b0;
        zero_above = 1'b1;
        anode_d    = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (count_q[i*BCD_W +: BCD_W] == 4'd0);
            if (idx_q == IW'(i)) begin
                sel_digit  = count_q[i*BCD_W +: BCD_W];
                blank_sel  = (BLANK_LZ != 0) && (i != 0) && zero_above;
                anode_d[i] = 1'b0;
            end
        end
        cathode_d = {DP_OFF, blank_sel ? SEG_BLANK : seg};
    end

    seg7_decode u_decode (
        .bcd_i (sel_digit),
        .seg_o (seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            scan_q    <= '0;
            idx_q     <= '0;
            anode_q   <= '1;
            cathode_q <= 8'hFF;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode     = anode_q;
    assign cathode   = cathode_q;
    assign count_bcd = count_q;
    assign wrap      = wrap_q;
endmodule
`default_nettype wire

// File: tb/tb_counter_7seg_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_counter_7seg_mux : randomised bench with a decimal-arithmetic model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_counter_7seg_mux;
    localparam int N   = 4;
    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int BLZ = 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         up_dn = 1'b1;
    logic         clear = 1'b0;
    logic [N-1:0] anode;
    logic [7:0]   cathode;
    logic [4*N-1:0] count_bcd;
    logic         wrap;

    counter_7seg_mux #(
        .NUM_DIGITS (N),
        .TICK_DIV   (TD),
        .SCAN_DIV   (SD),
        .BLANK_LZ   (BLZ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .clear     (clear),
        .anode     (anode),
        .cathode   (cathode),
        .count_bcd (count_bcd),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b1;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model state: the count as a plain integer, dividers as integers.
    int           m_cnt = 0, m_pre = 0, m_scan = 0, m_idx = 0;
    logic         m_wrap = 1'b0;
    logic [N-1:0] m_anode = '1;
    logic [7:0]   m_cathode = 8'hFF;

    function automatic int p10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int nc, np, ns, ni, dg;
        logic nw;
        if (!rst_n) begin
            m_cnt <= 0; m_pre <= 0; m_scan <= 0; m_idx <= 0;
            m_wrap <= 1'b0; m_anode <= '1; m_cathode <= 8'hFF;
        end else begin
            m_anode <= ~(N'(1) << m_idx);
            dg = (m_cnt / p10(m_idx)) % 10;
            if (BLZ != 0 && m_idx > 0 && m_cnt < p10(m_idx)) m_cathode <= 8'hFF;
            else m_cathode <= {1'b1, seg_tab[dg]};
            nc = m_cnt; np = m_pre; nw = 1'b0;
            if (clear) begin
                nc = 0; np = 0;
            end else if (en) begin
                if (m_pre == TD - 1) begin
                    np = 0;
                    if (up_dn) begin
                        if (m_cnt == p10(N) - 1) begin nc = 0; nw = 1'b1; end
                        else nc = m_cnt + 1;
                    end else begin
                        if (m_cnt == 0) begin nc = p10(N) - 1; nw = 1'b1; end
                        else nc = m_cnt - 1;
                    end
                end else np = m_pre + 1;
            end
            if (m_scan == SD - 1) begin ns = 0; ni = (m_idx + 1) % N; end
            else begin ns = m_scan + 1; ni = m_idx; end
            m_cnt <= nc; m_pre <= np; m_wrap <= nw; m_scan <= ns; m_idx <= ni;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_total++;
            if ({count_bcd, wrap, anode, cathode} === {to_bcd(m_cnt), m_wrap, m_anode, m_cathode})
                n_pass++;
            else
                $display("FAIL cycle t=%0t count got %h want %h, wrap got %b want %b, anode got %h want %h, cathode got %h want %h",
                         $time, count_bcd, to_bcd(m_cnt), wrap, m_wrap, anode, m_anode, cathode, m_cathode);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %h want %h", nm, got, want);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_cnt(input int target, input int budget, input string nm);
        int k = 0;
        while (m_cnt != target && k < budget) begin step(1); k++; end
        if (m_cnt != target) begin
            n_total++;
            $display("FAIL %s timeout got %0d want %0d", nm, m_cnt, target);
        end
    endtask

    task automatic wait_wrap(input int budget, input string nm);
        int k = 0;
        while (wrap !== 1'b1 && k < budget) begin step(1); k++; end
        if (wrap !== 1'b1) begin
            n_total++;
            $display("FAIL %s wrap timeout got %b want 1", nm, wrap);
        end
    endtask

    logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_ca [4] = '{8'hA4, 8'hF9, 8'hFF, 8'hFF};

    initial begin
        int k;
        rst_n = 1'b0;
        step(3);
        check("rst_anode",   32'(anode),     32'hF);
        check("rst_cathode", 32'(cathode),   32'hFF);
        check("rst_count",   32'(count_bcd), 32'h0);
        check("rst_wrap",    32'(wrap),      32'h0);
        rst_n = 1'b1;
        en    = 1'b1;
        up_dn = 1'b1;

        wait_cnt(12, 100, "up12");
        check("up12_count", 32'(count_bcd), 32'h0012);
        en = 1'b0;
        k = 0;
        while (anode !== 4'hE && k < 10) begin step(1); k++; end
        for (int s = 0; s < 4; s++) begin
            check("scan_anode",   32'(anode),   32'(exp_an[s]));
            check("scan_cathode", 32'(cathode), 32'(exp_ca[s]));
            step(2);
        end
        step(12);
        check("hold_count", 32'(count_bcd), 32'h0012);
        en = 1'b1;

        wait_cnt(9999, 45000, "to9999");
        check("full_count", 32'(count_bcd), 32'h9999);
        wait_wrap(10, "upwrap");
        check("upwrap_count", 32'(count_bcd), 32'h0000);
        step(1);
        check("upwrap_single", 32'(wrap), 32'h0);

        up_dn = 1'b0;
        wait_wrap(10, "dnwrap");
        check("dnwrap_count", 32'(count_bcd), 32'h9999);
        wait_cnt(9998, 10, "dn9998");
        check("dn9998_count", 32'(count_bcd), 32'h9998);

        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_count", 32'(count_bcd), 32'h0000);
        k = 0;
        while (m_pre != TD - 1 && k < 10) begin step(1); k++; end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("cleartick_count", 32'(count_bcd), 32'h0000);
        check("cleartick_wrap",  32'(wrap),      32'h0);
        step(1);
        check("cleartick_wrap2", 32'(wrap),      32'h0);

        up_dn = 1'b1;
        wait_cnt(47, 400, "to47");
        check("mid_count", 32'(count_bcd), 32'h0047);
        #1 rst_n = 1'b0;
        #1;
        check("async_anode",   32'(anode),     32'hF);
        check("async_cathode", 32'(cathode),   32'hFF);
        check("async_count",   32'(count_bcd), 32'h0);
        check("async_wrap",    32'(wrap),      32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_cnt(1, 20, "resume");
        check("resume_count", 32'(count_bcd), 32'h0001);

        repeat (600) begin
            en    = ($urandom_range(0, 3) != 0);
            up_dn = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 15) == 0);
            step(1);
        end
        clear = 1'b0;
        step(2);
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
